// File: rtl/mod_keypad_pkg.sv
// Shared definitions for the mod_keypad scanner: register map, STATUS layout,
// column strobe reset value, key-code widths and a lowest-set-bit helper.
package mod_keypad_pkg;

   localparam logic [31:0] KP_DATA   = 32'h0000_0000;
   localparam logic [31:0] KP_STATUS = 32'h0000_0004;
   localparam int          KP_SEL_BIT = 2;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_EMPTY     = 4;
   localparam int ST_FULL      = 5;
   localparam int ST_OVF       = 6;
   localparam int ST_DEB_LSB   = 8;

   localparam logic [3:0] KP_COL_RESET = 4'b1110;

   localparam int KEY_W  = 4;
   localparam int CODE_W = 5;

   typedef logic [KEY_W-1:0]  key_t;
   typedef logic [CODE_W-1:0] code_t;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic key_t lowest_set(input logic [15:0] mask);
      key_t idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) idx = key_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/kp_fifo.sv
// Synchronous key-event FIFO (negedge clocked) with push, pop, flush and
// full/empty/count status. DEPTH must be a power of two, at least 2.
module kp_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 5,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr_q];

   // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop & ~empty;
      // A pop in the same cycle frees the slot a full-FIFO push needs.
      do_push  = push & (~full | do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(negedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy is tracked by the pointers, so stale words are never read.
   always_ff @(negedge clk) begin
      if (do_push && !flush) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mod_keypad.sv
// Memory-mapped 4x4 keypad scanner with debounce and key-event FIFO.
// Optional release events are enabled by defining KEYPAD_RELEASE_EN.
module mod_keypad
   import mod_keypad_pkg::*;
#(
   parameter int CLOCK_FREQ = 25000000,
   parameter int SCAN_HZ    = 1000,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ie,
   input  logic        de,
   input  logic [31:0] iaddr,
   input  logic [31:0] daddr,
   input  logic [1:0]  drw,
   input  logic [31:0] din,
   output logic [31:0] iout,
   output logic [31:0] dout,
   output logic [3:0]  kp_col,
   input  logic [3:0]  kp_row
);

   localparam int              TICKS     = CLOCK_FREQ / SCAN_HZ;
   localparam int              TICK_W    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
   localparam logic [3:0]      DEB_MAX   = 4'(DEBOUNCE);
   localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]        row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [3:0]        kp_col_q, kp_col_d;
   logic [15:0]       raw_q, raw_d, prev_q, prev_d, deb_q, deb_d, pend_q, pend_d;
   logic [3:0]        stable_q, stable_d;
   logic              ovf_q, ovf_d;
`ifdef KEYPAD_RELEASE_EN
   logic [15:0]       relpend_q, relpend_d;
   logic [15:0]       new_rel;
`endif

   logic [15:0]       raw_next, new_press;
   logic              sweep_end;
   key_t              sel_idx;
   logic              push;
   code_t             push_code;
   code_t             fifo_head;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [3:0]        count4;
   logic              bus_rd, data_rd, st_wr, flush, clr_ovf, pop;

   logic unused_ok;
   assign unused_ok = ^{ie, iaddr, daddr[31:3], daddr[1:0], din[31:2]};

   assign iout    = '0;
   assign kp_col  = kp_col_q;
   assign count4  = 4'(fifo_count);
   assign bus_rd  = de & drw[1];
   assign data_rd = bus_rd & ~daddr[KP_SEL_BIT];
   assign st_wr   = de & drw[0] & daddr[KP_SEL_BIT];
   assign flush   = st_wr & din[0];
   assign clr_ovf = st_wr & din[1];
   assign pop     = data_rd & ~fifo_empty;

   always_comb begin
      row_s1_d  = kp_row;
      row_s2_d  = row_s1_q;
      tick_d    = tick_q + TICK_W'(1);
      col_idx_d = col_idx_q;
      kp_col_d  = kp_col_q;
      raw_d     = raw_q;
      prev_d    = prev_q;
      deb_d     = deb_q;
      stable_d  = stable_q;
      raw_next  = raw_q;
      new_press = '0;
      sweep_end = 1'b0;
`ifdef KEYPAD_RELEASE_EN
      new_rel   = '0;
`endif

      // Maps are indexed by key code (row*4 + col) so the lowest pending bit is the lowest code.
      if (tick_q == TICK_LAST) begin
         tick_d = '0;
         for (int r = 0; r < 4; r++) raw_next[{2'(r), col_idx_q}] = ~row_s2_q[r];
         raw_d     = raw_next;
         col_idx_d = col_idx_q + 2'd1;
         kp_col_d  = {kp_col_q[2:0], kp_col_q[3]};
         sweep_end = (col_idx_q == 2'd3);
      end

      if (sweep_end) begin
         prev_d = raw_next;
         if (raw_next == prev_q) stable_d = (stable_q == DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
         else                    stable_d = '0;
         if (stable_d == DEB_MAX && raw_next != deb_q) begin
            new_press = raw_next & ~deb_q;
`ifdef KEYPAD_RELEASE_EN
            new_rel   = deb_q & ~raw_next;
`endif
            deb_d     = raw_next;
         end
      end
   end

   // Event selection: one push per cycle, presses ahead of releases.
   always_comb begin
      sel_idx   = '0;
      push      = 1'b0;
      push_code = '0;
      pend_d    = pend_q | new_press;
`ifdef KEYPAD_RELEASE_EN
      relpend_d = relpend_q | new_rel;
      if (pend_q != '0) begin
         sel_idx         = lowest_set(pend_q);
         push            = 1'b1;
         push_code       = {1'b0, sel_idx};
         pend_d[sel_idx] = new_press[sel_idx];
      end else if (relpend_q != '0) begin
         sel_idx            = lowest_set(relpend_q);
         push               = 1'b1;
         push_code          = {1'b1, sel_idx};
         relpend_d[sel_idx] = new_rel[sel_idx];
      end
      if (flush) relpend_d = '0;
`else
      if (pend_q != '0) begin
         sel_idx         = lowest_set(pend_q);
         push            = 1'b1;
         push_code       = {1'b0, sel_idx};
         pend_d[sel_idx] = new_press[sel_idx];
      end
`endif
      if (flush) pend_d = '0;

      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (push && fifo_full && !pop && !flush) ovf_d = 1'b1;
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         row_s1_q  <= 4'hF;
         row_s2_q  <= 4'hF;
         tick_q    <= '0;
         col_idx_q <= '0;
         kp_col_q  <= KP_COL_RESET;
         raw_q     <= '0;
         prev_q    <= '0;
         deb_q     <= '0;
         stable_q  <= '0;
         pend_q    <= '0;
         ovf_q     <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
         relpend_q <= '0;
`endif
      end else begin
         row_s1_q  <= row_s1_d;
         row_s2_q  <= row_s2_d;
         tick_q    <= tick_d;
         col_idx_q <= col_idx_d;
         kp_col_q  <= kp_col_d;
         raw_q     <= raw_d;
         prev_q    <= prev_d;
         deb_q     <= deb_d;
         stable_q  <= stable_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
`ifdef KEYPAD_RELEASE_EN
         relpend_q <= relpend_d;
`endif
      end
   end

   kp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_code),
      .pop       (pop),
      .flush     (flush),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      dout = '0;
      if (bus_rd) begin
         if (daddr[KP_SEL_BIT])
            dout = {8'b0, deb_q, 1'b0, ovf_q, fifo_full, fifo_empty, count4};
         else if (!fifo_empty)
            dout = {23'b0, 1'b1, 3'b0, fifo_head};
      end
   end

endmodule
